// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the ALU and the iterative multiply/divide controller.
// Also holds the operand-magnitude helper used at the accept edge.
package muldiv_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/result bundle between the decode stage and the multiply/divide controller.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hilo;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, rd_hilo, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, rd_hilo, flush,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on a 64-bit accumulator.
// Multiply leaves the product in acc; divide leaves remainder in acc[63:32], quotient in acc[31:0].
module muldiv_step (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step_en,
    input  logic        load_div,
    input  logic [31:0] a_mag,
    input  logic [31:0] b_mag,
    output logic [63:0] acc
);

    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        div_q;

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        ge;
    logic [63:0] acc_step;

    // The shifted partial remainder needs 33 bits; when it is >= divisor the
    // true difference fits back into 32 bits, so modulo-2^32 subtraction suffices.
    always_comb begin
        sum      = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        rem_sh   = acc_q[63:31];
        diff     = rem_sh[31:0] - opnd_q;
        ge       = (rem_sh >= {1'b0, opnd_q});
        acc_step = acc_q;
        if (div_q) begin
            acc_step = ge ? {diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
            acc_step = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= 64'd0;
            opnd_q <= 32'd0;
            div_q  <= 1'b0;
        end else if (load) begin
            acc_q  <= {32'd0, load_div ? a_mag : b_mag};
            opnd_q <= load_div ? b_mag : a_mag;
            div_q  <= load_div;
        end else if (step_en) begin
            acc_q  <= acc_step;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller: FSM, iteration down-counter, sign fix and HI/LO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; MTHI/MTLO write HI/LO directly here
//   RUN     | one datapath step per cycle until the counter reaches zero
//   FIX     | sign-correct the raw result, write HI/LO on exit
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int ITER_BITS = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    localparam int CW = $clog2(ITER_BITS + 1);

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          div_q;
    logic          neg_res_q;
    logic          neg_rem_q;
    logic          div_zero_q;
    logic [31:0]   hi_q, lo_q;
    logic          done_q;

    logic          load, step_en, write_res, mt_hi, mt_lo, done_d;
    logic          op_signed, op_div, op_iter;
    logic [31:0]   a_mag, b_mag;
    logic [63:0]   acc;
    logic [63:0]   prod_fix;
    logic [31:0]   quo_fix, rem_fix;

    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_iter   = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || op_div;
    assign a_mag     = mag32(bus.a, op_signed);
    assign b_mag     = mag32(bus.b, op_signed);

    muldiv_step u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step_en  (step_en),
        .load_div (op_div),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc      (acc)
    );

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step_en   = 1'b0;
        write_res = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (op_iter) begin
                        state_d = ST_RUN;
                        load    = 1'b1;
                    end else begin
                        mt_hi = (bus.op == OP_MTHI);
                        mt_lo = (bus.op == OP_MTLO);
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    step_en = 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    write_res = 1'b1;
                    done_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    always_comb begin
        prod_fix = neg_res_q ? (~acc + 64'd1) : acc;
        quo_fix  = (neg_res_q && !div_zero_q) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem_q ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                cnt_q      <= CW'(ITER_BITS);
                div_q      <= op_div;
                neg_res_q  <= op_signed & (bus.a[31] ^ bus.b[31]);
                neg_rem_q  <= op_signed & bus.a[31];
                div_zero_q <= (bus.b == 32'd0);
            end else if (step_en) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (write_res) begin
                if (div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end
            end else if (mt_hi) begin
                hi_q <= bus.a;
            end else if (mt_lo) begin
                lo_q <= bus.a;
            end
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.stall = bus.busy & (bus.rd_hilo | bus.start);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO/latency queued at issue, checked on each done pulse.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.ITER_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("hi",      {32'd0, bus.hi}, {32'd0, mon_e.hi});
                check("lo",      {32'd0, bus.lo}, {32'd0, mon_e.lo});
                check("latency", 64'(cyc),        64'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input muldiv_op_t op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         input bit push, input logic [31:0] eh, input logic [31:0] el);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) sb.push_back('{eh, el, cyc + 34});
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic count_dones(input string name, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) c++;
        end
        check(name, 64'(c), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.start   = 1'b0;
        bus.op      = OP_MULTU;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.rd_hilo = 1'b0;
        bus.flush   = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hi",    {32'd0, bus.hi}, 64'd0);
        check("rst_lo",    {32'd0, bus.lo}, 64'd0);
        check("rst_busy",  64'(bus.busy),   64'd0);
        check("rst_stall", 64'(bus.stall),  64'd0);
        check("rst_done",  64'(bus.done),   64'd0);
        rst = 1'b0;

        // MULTU max * 2
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE);
        wait_done("multu_done");

        // MULT -3 * 7, busy held through RUN/FIX; a start while busy is ignored
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        ok = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) ok = 1'b0;
            if (i == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MULTU;
                bus.a     = 32'd11;
                bus.b     = 32'd11;
                #1;
                check("stall_on_start", 64'(bus.stall), 64'd1);
            end
            if (i == 6) bus.start = 1'b0;
        end
        check("mult_busy_run_fix", 64'(ok), 64'd1);
        @(negedge clk);
        check("mult_busy_done_cycle", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("start_while_busy_ignored", 64'(bus.busy), 64'd0);

        // Divides, including both divide-by-zero flavours and the overflow case
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_done");
        issue(OP_DIVU, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFF_FFFF);
        wait_done("divu_zero_done");
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        wait_done("div_zero_done");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000);
        wait_done("div_ovf_done");
        issue(OP_DIVU, 32'd1000, 32'd7, 1'b1, 32'd6, 32'd142);
        wait_done("divu_done");

        // MTHI in IDLE, then MULTU with rd_hilo held
        issue(OP_MTHI, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0);
        check("mthi_hi",   {32'd0, bus.hi}, 64'h1234);
        check("mthi_busy", 64'(bus.busy),   64'd0);
        @(negedge clk);
        check("mthi_no_done", 64'(bus.done), 64'd0);
        bus.rd_hilo = 1'b1;
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
        ok = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (bus.stall !== 1'b1) ok = 1'b0;
        end
        check("stall_busy_cycles", 64'(ok), 64'd1);
        @(negedge clk);
        check("stall_done_cycle", 64'(bus.stall), 64'd0);
        bus.rd_hilo = 1'b0;

        // Flush at RUN iteration 10
        issue(OP_MULTU, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy),   64'd0);
        check("flush_hi",   {32'd0, bus.hi}, 64'd0);
        check("flush_lo",   {32'd0, bus.lo}, 64'd42);
        count_dones("flush_no_done", 40);

        issue(OP_MULTU, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15);
        wait_done("after_flush_done");

        // Flush beats start in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        count_dones("flush_start_no_done", 5);

        // Asynchronous reset mid-DIVU
        bus.rd_hilo = 1'b1;
        issue(OP_DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        check("stall_pre_rst", 64'(bus.stall), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hi",    {32'd0, bus.hi}, 64'd0);
        check("arst_lo",    {32'd0, bus.lo}, 64'd0);
        check("arst_busy",  64'(bus.busy),   64'd0);
        check("arst_stall", 64'(bus.stall),  64'd0);
        check("arst_done",  64'(bus.done),   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_hilo = 1'b0;
        count_dones("rst_no_done", 40);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
